// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths, constants and FSM encoding for the
// register-file write arbiter slice.
package regfile_wr_arbiter_pkg;

  localparam int AddrW = 5;
  localparam int DataW = 32;
  localparam int NRegs = 32;

  localparam logic WriteEnable = 1'b1;
  localparam logic [DataW-1:0] ZeroWord = '0;
  localparam logic [AddrW-1:0] ZeroAddr = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_HOLD  = 2'b01,
    S_FORCE = 2'b10
  } arb_state_e;

  function automatic logic [NRegs-1:0] onehot(
    input logic en,
    input logic [AddrW-1:0] a
  );
    logic [NRegs-1:0] v;
    v = '0;
    if (en && a != ZeroAddr) v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_scoreboard.sv
// Pending-write scoreboard for long-latency unit destinations.
// Set wins over a same-cycle clear; r0 is never reserved.
module reg_scoreboard
  import regfile_wr_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AddrW-1:0] set_addr,
  input  logic             clr_en,
  input  logic [AddrW-1:0] clr_addr,
  input  logic [AddrW-1:0] raddr1,
  input  logic [AddrW-1:0] raddr2,
  output logic             busy1,
  output logic             busy2,
  output logic             dup_err
);

  logic [NRegs-1:0] pend_q, pend_d;
  logic [NRegs-1:0] set_v, clr_v;

  always_comb begin
    set_v  = onehot(set_en, set_addr);
    clr_v  = onehot(clr_en, clr_addr);
    pend_d = (pend_q & ~clr_v) | set_v;
    pend_d[0] = 1'b0;
  end

  assign dup_err = |(set_v & pend_q);
  assign busy1   = pend_q[raddr1];
  assign busy2   = pend_q[raddr2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single regfile write port between pipeline
// writeback and a one-entry long-unit result buffer.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_we,
  input  logic [AddrW-1:0] wb_waddr,
  input  logic [DataW-1:0] wb_wdata,
  input  logic             lu_issue,
  input  logic [AddrW-1:0] lu_issue_addr,
  input  logic             lu_valid,
  input  logic [AddrW-1:0] lu_waddr,
  input  logic [DataW-1:0] lu_wdata,
  output logic             lu_ready,
  input  logic [AddrW-1:0] raddr1,
  input  logic [AddrW-1:0] raddr2,
  output logic             busy1,
  output logic             busy2,
  output logic             rf_we,
  output logic [AddrW-1:0] rf_waddr,
  output logic [DataW-1:0] rf_wdata,
  output logic             stall_req,
  output logic             protocol_err
);

  localparam logic [2:0] Limit = 3'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [AddrW-1:0] buf_addr_q, buf_addr_d;
  logic [DataW-1:0] buf_data_q, buf_data_d;
  logic [2:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic             buf_valid, capture, drain;
  logic             dup_err;

  assign buf_valid = (state_q != S_IDLE);
  assign lu_ready  = ~buf_valid;
  assign stall_req = (state_q == S_FORCE);
  // r0 results are accepted but never buffered
  assign capture   = lu_valid & lu_ready & (lu_waddr != ZeroAddr);
  assign drain     = stall_req | (buf_valid & ~wb_we);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ZeroAddr;
    rf_wdata = ZeroWord;
    priority case (1'b1)
      stall_req: begin
        rf_we    = WriteEnable;
        rf_waddr = buf_addr_q;
        rf_wdata = buf_data_q;
      end
      wb_we: begin
        rf_we    = WriteEnable;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end
      buf_valid: begin
        rf_we    = WriteEnable;
        rf_waddr = buf_addr_q;
        rf_wdata = buf_data_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    wait_d     = wait_q;
    err_d      = dup_err | (stall_req & wb_we);
    unique case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d    = S_HOLD;
          buf_addr_d = lu_waddr;
          buf_data_d = lu_wdata;
        end
      end
      S_HOLD: begin
        if (drain) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end else if (wait_q + 3'd1 == Limit) begin
          state_d = S_FORCE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_FORCE: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      buf_addr_q <= ZeroAddr;
      buf_data_q <= ZeroWord;
      wait_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
    end
  end

  assign protocol_err = err_q;

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (lu_issue),
    .set_addr (lu_issue_addr),
    .clr_en   (drain),
    .clr_addr (buf_addr_q),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .busy1    (busy1),
    .busy2    (busy2),
    .dup_err  (dup_err)
  );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed, table-driven bench for regfile_wr_arbiter
// (default STARVE_LIMIT=3) plus a mid-operation reset sequence.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic [4:0]  raddr1, raddr2;
  logic        busy1, busy2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .wb_we         (wb_we),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .lu_issue      (lu_issue),
    .lu_issue_addr (lu_issue_addr),
    .lu_valid      (lu_valid),
    .lu_waddr      (lu_waddr),
    .lu_wdata      (lu_wdata),
    .lu_ready      (lu_ready),
    .raddr1        (raddr1),
    .raddr2        (raddr2),
    .busy1         (busy1),
    .busy2         (busy2),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .stall_req     (stall_req),
    .protocol_err  (protocol_err)
  );

  // {ready,busy1,busy2,rf_we,rf_waddr,rf_wdata,stall,err}
  typedef struct packed {
    logic        wb_we;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic        iss;
    logic [4:0]  iss_a;
    logic        lv;
    logic [4:0]  lw_a;
    logic [31:0] lw_d;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [42:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic is, input logic [4:0] ia,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic e_rdy, input logic e_b1, input logic e_b2,
    input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
    input logic e_st, input logic e_er
  );
    vec_t v;
    v.wb_we = we; v.wb_a = wa; v.wb_d = wd;
    v.iss = is; v.iss_a = ia;
    v.lv = lv; v.lw_a = la; v.lw_d = ld;
    v.ra1 = r1; v.ra2 = r2;
    v.exp = {e_rdy, e_b1, e_b2, e_we, e_wa, e_wd, e_st, e_er};
    return v;
  endfunction

  function automatic logic [42:0] outs();
    return {lu_ready, busy1, busy2, rf_we, rf_waddr, rf_wdata,
            stall_req, protocol_err};
  endfunction

  task automatic check(input string name, input logic [42:0] act,
                       input logic [42:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wb_we = v.wb_we; wb_waddr = v.wb_a; wb_wdata = v.wb_d;
    lu_issue = v.iss; lu_issue_addr = v.iss_a;
    lu_valid = v.lv; lu_waddr = v.lw_a; lu_wdata = v.lw_d;
    raddr1 = v.ra1; raddr2 = v.ra2;
  endtask

  task automatic idle_in();
    drive(mk(0,0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,0));
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    @(negedge clk); #1;
    check("reset_state", outs(), {1'b1,1'b0,1'b0,1'b0,5'd0,32'd0,1'b0,1'b0});
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h33; #1;
    check("reset_wb_pass", outs(),
          {1'b1,1'b0,1'b0,1'b1,5'd3,32'h33,1'b0,1'b0});
    @(negedge clk);
    rst = 1'b0;

    vq.push_back(mk(0,0,0,      0,0,  0,0,0,        9,0,  1,0,0, 0,0,0,       0,0));
    vq.push_back(mk(1,2,'h22,   0,0,  0,0,0,        9,0,  1,0,0, 1,2,'h22,    0,0));
    vq.push_back(mk(0,0,0,      1,9,  0,0,0,        9,0,  1,0,0, 0,0,0,       0,0));
    vq.push_back(mk(0,0,0,      1,5,  0,0,0,        9,0,  1,1,0, 0,0,0,       0,0));
    vq.push_back(mk(0,0,0,      1,9,  0,0,0,        5,0,  1,1,0, 0,0,0,       0,0));
    vq.push_back(mk(0,0,0,      0,0,  0,0,0,        9,0,  1,1,0, 0,0,0,       0,1));
    vq.push_back(mk(0,0,0,      0,0,  1,5,'h1234,   5,0,  1,1,0, 0,0,0,       0,0));
    vq.push_back(mk(0,0,0,      0,0,  0,0,0,        5,0,  0,1,0, 1,5,'h1234,  0,0));
    vq.push_back(mk(0,0,0,      0,0,  0,0,0,        5,0,  1,0,0, 0,0,0,       0,0));
    vq.push_back(mk(1,1,'h11,   0,0,  1,9,'h99,     9,0,  1,1,0, 1,1,'h11,    0,0));
    vq.push_back(mk(1,2,'h21,   0,0,  0,0,0,        9,0,  0,1,0, 1,2,'h21,    0,0));
    vq.push_back(mk(1,3,'h31,   0,0,  0,0,0,        9,0,  0,1,0, 1,3,'h31,    0,0));
    vq.push_back(mk(1,4,'h41,   0,0,  0,0,0,        9,0,  0,1,0, 1,4,'h41,    0,0));
    vq.push_back(mk(0,0,0,      0,0,  0,0,0,        9,0,  0,1,0, 1,9,'h99,    1,0));
    vq.push_back(mk(1,6,'h61,   0,0,  0,0,0,        9,0,  1,0,0, 1,6,'h61,    0,0));
    vq.push_back(mk(1,8,'h81,   0,0,  1,7,'h77,     0,0,  1,0,0, 1,8,'h81,    0,0));
    vq.push_back(mk(1,8,'h82,   0,0,  0,0,0,        0,0,  0,0,0, 1,8,'h82,    0,0));
    vq.push_back(mk(1,8,'h83,   0,0,  0,0,0,        0,0,  0,0,0, 1,8,'h83,    0,0));
    vq.push_back(mk(1,8,'h84,   0,0,  0,0,0,        0,0,  0,0,0, 1,8,'h84,    0,0));
    vq.push_back(mk(1,8,'h85,   0,0,  0,0,0,        0,0,  0,0,0, 1,7,'h77,    1,0));
    vq.push_back(mk(1,8,'h86,   0,0,  0,0,0,        0,0,  1,0,0, 1,8,'h86,    0,1));
    vq.push_back(mk(1,8,'h87,   0,0,  0,0,0,        0,0,  1,0,0, 1,8,'h87,    0,0));
    vq.push_back(mk(0,0,0,      0,0,  1,0,'hDEAD,   0,0,  1,0,0, 0,0,0,       0,0));
    vq.push_back(mk(0,0,0,      0,0,  0,0,0,        0,0,  1,0,0, 0,0,0,       0,0));
    vq.push_back(mk(0,0,0,      1,10, 0,0,0,        10,0, 1,0,0, 0,0,0,       0,0));
    vq.push_back(mk(0,0,0,      0,0,  1,10,'hA0,    10,0, 1,1,0, 0,0,0,       0,0));
    vq.push_back(mk(0,0,0,      1,10, 0,0,0,        10,0, 0,1,0, 1,10,'hA0,   0,0));
    vq.push_back(mk(0,0,0,      0,0,  0,0,0,        10,10,1,1,1, 0,0,0,       0,1));

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check($sformatf("vec%0d", i), outs(), vq[i].exp);
    end

    // Mid-operation reset with r4 reserved and buffered
    @(negedge clk);
    idle_in();
    lu_issue = 1'b1; lu_issue_addr = 5'd4;
    @(negedge clk);
    idle_in();
    lu_valid = 1'b1; lu_waddr = 5'd4; lu_wdata = 32'h44;
    @(negedge clk);
    idle_in();
    wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'h11;
    raddr1 = 5'd4; raddr2 = 5'd10;
    #1;
    check("hold_r4", outs(),
          {1'b0,1'b1,1'b1,1'b1,5'd1,32'h11,1'b0,1'b0});
    rst = 1'b1;
    #1;
    check("rst_async", outs(),
          {1'b1,1'b0,1'b0,1'b1,5'd1,32'h11,1'b0,1'b0});
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    raddr1 = 5'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("post_rst%0d", k), outs(),
            {1'b1,1'b0,1'b0,1'b0,5'd0,32'd0,1'b0,1'b0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
